fusion_src_gen: RTL and testbench

Single-clock dual-channel RGB888 pixel source that drives the two-input weighted-fusion path. It produces the `ch1`/`ch2` data/valid streams and the one-pixel `move_r` shift request with programmable frame timing, test patterns and inter-channel skew. It sits upstream of the fusion block for bring-up, on-board self-test and simulation, and can replace the camera inputs.

---
 rtl/fusion_pkg.sv | 21 ++
 rtl/fusion_src_dly.sv | 34 +++
 rtl/fusion_src_gen.sv | 158 +++++++++++++++
 tb/tb_fusion_src_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fusion_pkg.sv
// Shared encodings for the fusion test-pattern source: FSM states,
// pattern codes and the colour-bar palette.
package fusion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_HRAMP = 2'd1;
  localparam logic [1:0] PAT_VRAMP = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam logic [23:0] BAR_COLOR [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/fusion_src_dly.sv
// Register line for the {valid, data} bundle of channel 2; DEPTH=0 is a
// plain wire.
module fusion_src_dly #(
  parameter int unsigned DEPTH = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [24:0] din,
  output logic [24:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      // clock and reset have no loads in the pass-through case
      logic unused_clk_rst;
      assign unused_clk_rst = clk & rst_n;
      assign dout = din;
    end else begin : g_line
      logic [24:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fusion_src_gen.sv
// Dual-channel RGB888 pattern source feeding the weighted-fusion path:
// frame timing, four test patterns, ch2 complement/skew and move_r strobe.
module fusion_src_gen
  import fusion_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 370,
  parameter int V_ACTIVE = 720,
  parameter int V_BLANK  = 30,
  parameter int CH2_DLY  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic        shift_req,
  output logic [23:0] ch1_data,
  output logic        ch1_valid,
  output logic [23:0] ch2_data,
  output logic        ch2_valid,
  output logic        move_r,
  output logic        sof,
  output logic        busy
);

  localparam int H_TOT = H_ACTIVE + H_BLANK;
  localparam int V_TOT = V_ACTIVE + V_BLANK;
  localparam int H_W   = $clog2(H_TOT);
  localparam int V_W   = $clog2(V_TOT);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int B_W   = $clog2(BAR_W + 1);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOT - 1);
  localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOT - 1);
  localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
  localparam logic [B_W-1:0] B_LAST = B_W'(BAR_W - 1);

  state_t          state, state_nx;
  logic [H_W-1:0]  h_cnt;
  logic [V_W-1:0]  v_cnt;
  logic [B_W-1:0]  bar_px;
  logic [2:0]      bar_idx;
  logic [1:0]      pat;
  logic            pend;
  logic            run, latch_pat;
  logic            line_end, frame_end, active, fire;
  logic [7:0]      x8, y8;
  logic [23:0]     pix;
  logic [24:0]     dly_in, dly_out;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);
  assign active    = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign fire      = run && (h_cnt == H_ACT) && pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (enable) state_nx = ST_RUN;
      ST_RUN: begin
        if (frame_end)    state_nx = enable ? ST_RUN : ST_IDLE;
        else if (!enable) state_nx = ST_DRAIN;
      end
      ST_DRAIN: if (frame_end) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    run       = (state == ST_RUN) || (state == ST_DRAIN);
    busy      = run;
    latch_pat = enable && ((state == ST_IDLE) || ((state == ST_RUN) && frame_end));
  end

  // Bar position tracked alongside h_cnt so no divide by H_ACTIVE/8 is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (!run) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (line_end) begin
      h_cnt   <= '0;
      v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
      bar_px  <= '0;
      bar_idx <= '0;
    end else begin
      h_cnt <= h_cnt + H_W'(1);
      if (h_cnt < H_ACT) begin
        if (bar_px == B_LAST) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px  <= bar_px + B_W'(1);
        end
      end
    end
  end

  assign x8 = 8'(h_cnt);
  assign y8 = 8'(v_cnt);

  always_comb begin
    pix = '0;
    unique case (pat)
      PAT_BARS:  pix = BAR_COLOR[bar_idx];
      PAT_HRAMP: pix = {x8, x8, x8};
      PAT_VRAMP: pix = {y8, y8, y8};
      PAT_CHECK: pix = (x8[3] ^ y8[3]) ? 24'hFFFFFF : 24'h000000;
      default:   pix = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat       <= PAT_BARS;
      pend      <= 1'b0;
      move_r    <= 1'b0;
      ch1_valid <= 1'b0;
      ch1_data  <= '0;
      sof       <= 1'b0;
    end else begin
      if (latch_pat) pat <= pattern_sel;
      pend      <= (pend && !fire) || shift_req;
      move_r    <= fire;
      ch1_valid <= active;
      ch1_data  <= active ? pix : '0;
      sof       <= active && (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Complement only real pixels so ch2 stays all-zero while ch1 is idle.
  assign dly_in = {ch1_valid, ch1_valid ? ~ch1_data : 24'h000000};

  fusion_src_dly #(
    .DEPTH(CH2_DLY)
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (dly_in),
    .dout (dly_out)
  );

  assign ch2_valid = dly_out[24];
  assign ch2_data  = dly_out[23:0];

endmodule

// File: tb/tb_fusion_src_gen.sv
// Randomised self-checking bench for fusion_src_gen against a frame-position
// reference model.
module tb_fusion_src_gen;

  localparam int HA    = 16;
  localparam int HB    = 4;
  localparam int VA    = 4;
  localparam int VB    = 1;
  localparam int DLY   = 3;
  localparam int LINE  = HA + HB;
  localparam int FRAME = LINE * (VA + VB);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        shift_req = 1'b0;
  logic [23:0] ch1_data, ch2_data;
  logic        ch1_valid, ch2_valid, move_r, sof, busy;

  fusion_src_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .CH2_DLY(DLY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .shift_req(shift_req), .ch1_data(ch1_data), .ch1_valid(ch1_valid),
    .ch2_data(ch2_data), .ch2_valid(ch2_valid), .move_r(move_r),
    .sof(sof), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] pix(input int p, input int x, input int y);
    logic [7:0] xb, yb;
    xb = x[7:0];
    yb = y[7:0];
    case (p)
      0:       return bars[x / (HA / 8)];
      1:       return {xb, xb, xb};
      2:       return {yb, yb, yb};
      default: return (((x / 8) + (y / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Model: m_pos is the position within the frame this cycle while running.
  bit          m_busy = 0, m_stop = 0, m_pend = 0;
  int          m_pos = 0, m_pat = 0;
  logic        e_v = 0, e_sof = 0, e_mv = 0;
  logic [23:0] e_d = '0;
  logic [24:0] e_ch2 = '0;
  logic [24:0] hist [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_stop = 0; m_pend = 0; m_pos = 0; m_pat = 0;
      e_v = 0; e_d = '0; e_sof = 0; e_mv = 0; e_ch2 = '0;
      hist.delete();
      for (int i = 0; i <= DLY; i++) hist.push_back('0);
    end else begin
      int x, y;
      bit act, fire;
      x    = m_pos % LINE;
      y    = m_pos / LINE;
      act  = m_busy && x < HA && y < VA;
      fire = m_busy && x == HA && m_pend;
      e_v   = act;
      e_d   = act ? pix(m_pat, x, y) : 24'h0;
      e_sof = act && m_pos == 0;
      e_mv  = fire;
      m_pend = (m_pend && !fire) || shift_req;
      hist.push_back({e_v, e_v ? ~e_d : 24'h0});
      void'(hist.pop_front());
      e_ch2 = hist[0];
      if (!m_busy) begin
        if (enable) begin
          m_busy = 1; m_pos = 0; m_stop = 0; m_pat = int'(pattern_sel);
        end
      end else if (m_pos == FRAME - 1) begin
        m_pos = 0;
        if (enable && !m_stop) m_pat = int'(pattern_sel);
        else m_busy = 0;
      end else begin
        m_pos = m_pos + 1;
        if (!enable) m_stop = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_cmp++;
      if ({ch1_valid, ch1_data, ch2_valid, ch2_data, move_r, sof, busy} !==
          {e_v, e_d, e_ch2, e_mv, e_sof, m_busy}) begin
        n_bad++;
        $display("FAIL cycle t=%0t: got ch1=%b/%h ch2=%b/%h mv/sof/busy=%b%b%b, required ch1=%b/%h ch2=%b/%h mv/sof/busy=%b%b%b",
                 $time, ch1_valid, ch1_data, ch2_valid, ch2_data, move_r, sof, busy,
                 e_v, e_d, e_ch2[24], e_ch2[23:0], e_mv, e_sof, m_busy);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic wait_sof(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sof && k < 300);
    check(nm, 32'(sof), 32'd1);
  endtask

  task automatic drive_tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int k, s, v;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(ch1_valid), 32'd0);

    // Colour bars, enable held
    drive_tick();
    enable = 1'b1;
    wait_sof("first_sof");
    check("bar0", 32'(ch1_data), 32'hFFFFFF);
    repeat (4) @(negedge clk);
    check("bar2", 32'(ch1_data), 32'h00FFFF);
    repeat (11) @(negedge clk);
    check("bar7", 32'(ch1_data), 32'h000000);
    check("bar7_valid", 32'(ch1_valid), 32'd1);
    @(negedge clk);
    check("hblank_valid", 32'(ch1_valid), 32'd0);
    s = 0; v = 0;
    repeat (200) begin
      @(negedge clk);
      s += int'(sof);
      v += int'(ch1_valid);
    end
    check("sof_per_200", 32'(s), 32'd2);
    check("valid_per_200", 32'(v), 32'd128);

    // Two shift requests within one line collapse to one strobe
    k = 0;
    do begin @(negedge clk); k++; end while (!(m_pos % LINE == 3 && m_pos / LINE < VA) && k < 200);
    check("shift_sync", 32'(m_pos % LINE), 32'd3);
    drive_tick(); shift_req = 1'b1;
    drive_tick(); shift_req = 1'b0;
    repeat (2) drive_tick();
    shift_req = 1'b1;
    drive_tick(); shift_req = 1'b0;
    s = 0;
    repeat (2 * LINE) begin
      @(negedge clk);
      s += int'(move_r);
    end
    check("move_r_count", 32'(s), 32'd1);

    // Mid-frame pattern change takes effect on the next frame only
    drive_tick(); pattern_sel = 2'd1;
    wait_sof("sof_a");
    wait_sof("sof_hramp");
    repeat (8) @(negedge clk);
    check("hramp_x8", 32'(ch1_data), 32'h080808);
    drive_tick(); pattern_sel = 2'd3;
    repeat (10) @(negedge clk);
    check("hramp_kept", 32'(ch1_data), 32'h000000);
    wait_sof("sof_check");
    repeat (8) @(negedge clk);
    check("check_x8", 32'(ch1_data), 32'hFFFFFF);

    // Randomised run: shift pulses, pattern changes, enable toggles
    for (int i = 0; i < 1500; i++) begin
      drive_tick();
      shift_req = ($urandom_range(15) == 0);
      if ($urandom_range(299) == 0) enable = ~enable;
      if ($urandom_range(49) == 0) pattern_sel = 2'($urandom_range(3));
    end
    drive_tick();
    shift_req = 1'b0;
    enable = 1'b1;

    // Drop enable on line 2: frame completes, then idle
    k = 0;
    do begin @(negedge clk); k++; end while (!(m_busy && !m_stop && m_pos / LINE == 2) && k < 400);
    check("drop_sync", 32'(m_pos / LINE), 32'd2);
    drive_tick(); enable = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (busy && k < 150);
    check("drain_busy_low", 32'(busy), 32'd0);
    v = 0;
    repeat (60) begin
      @(negedge clk);
      v += int'(ch1_valid);
    end
    check("idle_no_valid", 32'(v), 32'd0);

    // Asynchronous reset mid-line
    drive_tick();
    pattern_sel = 2'd0;
    enable = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!(m_busy && m_pos % LINE == 7 && m_pos / LINE < VA) && k < 300);
    check("rst_sync", 32'(ch1_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_ch1", {7'd0, ch1_valid, ch1_data}, 32'd0);
    check("rst_ch2", {7'd0, ch2_valid, ch2_data}, 32'd0);
    check("rst_ctl", {29'd0, move_r, sof, busy}, 32'd0);
    drive_tick();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("restart_valid", 32'(ch1_valid), 32'd1);
    check("restart_sof", 32'(sof), 32'd1);
    check("restart_pix", 32'(ch1_data), 32'hFFFFFF);
    repeat (150) @(negedge clk);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
